// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
// Optional feature macro used by this slice: SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One spare bit so the bit counter reaches WIDTH-1 without wrapping.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle of the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
`ifdef SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
`ifdef SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output cout
  );

endinterface

// File: rtl/serial_adder_half_adder.sv
// Half adder used twice per bit slice of the serial adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock; {cout,sum} = a + b + cin.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output (bus.ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic             w_s0;
  logic             w_c0;
  logic             w_s;
  logic             w_c1;
  logic             w_carryNext;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  half_adder u_ha0 (
    .i_a (r_aSh[0]),
    .i_b (r_bSh[0]),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  half_adder u_ha1 (
    .i_a (w_s0),
    .i_b (r_carry),
    .o_s (w_s),
    .o_c (w_c1)
  );

  assign w_carryNext = w_c0 | w_c1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_nextState = ST_RUN;
      ST_RUN:  if (r_cnt == LAST_BIT) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == ST_RUN);
    w_accept = (r_state == ST_IDLE) && bus.start;
    w_last   = (r_state == ST_RUN) && (r_cnt == LAST_BIT);
  end

  // Result registers change only at completion; they hold across the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_aSh   <= bus.a;
        r_bSh   <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_aSh   <= r_aSh >> 1;
        r_bSh   <= r_bSh >> 1;
        r_res   <= {w_s, r_res[WIDTH-1:1]};
        r_carry <= w_carryNext;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum  <= {w_s, r_res[WIDTH-1:1]};
          r_cout <= w_carryNext;
`ifdef SERIAL_ADDER_OVF_EN
          // r_carry is still the carry into the MSB slice here.
          r_ovf  <= r_carry ^ w_carryNext;
`endif
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors push expectations, a done monitor pops them.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           doneCycle;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cycleCount = 0;
  int   doneCount = 0;
  int   pushCount = 0;
  logic doneAtStart;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0 at cycle %0d", cycleCount);
      end else begin
        e = sbQ.pop_front();
        checkOutput({e.name, "_sum"}, 32'(bus.sum), 32'(e.sum));
        checkOutput({e.name, "_cout"}, 32'(bus.cout), 32'(e.cout));
        checkOutput({e.name, "_latency"}, cycleCount, e.doneCycle);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({e.name, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic waitIdle(input string name);
    bit ok = 0;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_wait_idle actual=busy expected=idle within 50 cycles", name);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] expSum, input logic expCout, input logic expOvf,
                               input bit push, input string name);
    exp_t e;
    waitIdle(name);
    doneAtStart = bus.done;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(posedge clk);
    #1;
    checkOutput({name, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    if (push) begin
      e.sum = expSum;
      e.cout = expCout;
      e.ovf = expOvf;
      e.doneCycle = cycleCount + W;
      e.name = name;
      sbQ.push_back(e);
      pushCount++;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    #12;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_sum", 32'(bus.sum), 32'd0);
    checkOutput("reset_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1, "add_3c_0f");
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "ripple_ff_01");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1, "max_ff_ff_c1");
    applyStimulus(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1, "neg_80_80_c1");

    // Start and operand changes during a run must be ignored.
    applyStimulus(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0, 1, "midrun_55_22");
    doneBefore = doneCount;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.cin = 1'b1;
    @(negedge clk);
    checkOutput("midrun_still_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.cin = 1'b0;
    waitIdle("midrun");
    repeat (3) @(negedge clk);
    checkOutput("midrun_sum_hold", 32'(bus.sum), 32'h77);
    checkOutput("midrun_busy_idle", 32'(bus.busy), 32'd0);
    checkOutput("midrun_one_done", doneCount - doneBefore, 32'd1);

    // Second start lands in the done cycle of the first.
    applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1, "b2b_first");
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1, "b2b_second");
    checkOutput("b2b_done_at_accept", 32'(doneAtStart), 32'd1);

    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1, "ovf_7f_01");
    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "ovf_ff_01");
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1, "pre_abort_7f_01");

    // Abort a run with reset at bit 4; sum holds 8'h80 beforehand so clearing is visible.
    applyStimulus(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 0, "abort");
    doneBefore = doneCount;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_sum", 32'(bus.sum), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
    checkOutput("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", doneCount - doneBefore, 32'd0);
    checkOutput("abort_sum_stays_zero", 32'(bus.sum), 32'd0);

    applyStimulus(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1, "post_reset_3c_0f");
    waitIdle("final");
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 32'd0);
    checkOutput("done_count", doneCount, pushCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
